// File: rtl/parametrik_carpma_birimi_pkg.sv
// Shared definitions for the iterative multiply unit: one-hot op codes,
// FSM state encoding and a legality check for incoming op codes.
package carpma_paket;

   localparam logic [3:0] OP_MUL    = 4'h1;
   localparam logic [3:0] OP_MULH   = 4'h2;
   localparam logic [3:0] OP_MULHU  = 4'h4;
   localparam logic [3:0] OP_MULHSU = 4'h8;

   typedef enum logic [1:0] {
      BOS     = 2'd0,
      HESAPLA = 2'd1,
      SONUC   = 2'd2
   } durum_t;

   // True only for exactly one of the four supported op bits.
   function automatic logic kod_gecerli(input logic [3:0] kod);
      return (kod == OP_MUL) || (kod == OP_MULH) ||
             (kod == OP_MULHU) || (kod == OP_MULHSU);
   endfunction

endpackage

// File: rtl/parametrik_carpma_birimi_adim.sv
// One shift-add step of the multiplier.
//   a_mutlak : multiplicand magnitude
//   p        : current {upper, multiplier} register
//   p_yeni   : register after adding a_mutlak * p[ADIM_BIT-1:0] to the
//              upper half and shifting right by ADIM_BIT
module carpma_adimi #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADIM_BIT = 2
) (
   input  logic [XLEN-1:0]   a_mutlak,
   input  logic [2*XLEN-1:0] p,
   output logic [2*XLEN-1:0] p_yeni
);

   localparam int unsigned T_W = XLEN + ADIM_BIT;

   logic [T_W-1:0] toplam;

   // Sum cannot exceed XLEN+ADIM_BIT bits, so the carry lands in the top of P.
   always_comb begin
      toplam = T_W'(p[2*XLEN-1:XLEN]) + T_W'(a_mutlak) * T_W'(p[ADIM_BIT-1:0]);
      p_yeni = {toplam, p[XLEN-1:ADIM_BIT]};
   end

endmodule

// File: rtl/parametrik_carpma_birimi.sv
// Iterative RV32M/RV64M multiply unit (MUL/MULH/MULHU/MULHSU), ADIM_BIT
// multiplier bits per cycle, valid/ready on issue and result, tag and cancel.
//   clk_g, rst_g         : clock, synchronous active-low reset
//   islev_kodu_g         : one-hot op code
//   islec1_g / islec2_g  : rs1 multiplicand / rs2 multiplier
//   etiket_g             : tag returned with the result
//   hazir_g / kabul_c    : issue valid / issue ready
//   iptal_g              : cancel operation in flight
//   gecerli_c / oku_g    : result valid / result consumed
//   sonuc_c, etiket_c, hata_c : registered result, tag, illegal-op flag
module parametrik_carpma_birimi
   import carpma_paket::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADIM_BIT = 2,
   parameter int unsigned ETIKET_W = 4
) (
   input  logic                clk_g,
   input  logic                rst_g,
   input  logic [3:0]          islev_kodu_g,
   input  logic [XLEN-1:0]     islec1_g,
   input  logic [XLEN-1:0]     islec2_g,
   input  logic [ETIKET_W-1:0] etiket_g,
   input  logic                hazir_g,
   output logic                kabul_c,
   input  logic                iptal_g,
   output logic                gecerli_c,
   input  logic                oku_g,
   output logic [XLEN-1:0]     sonuc_c,
   output logic [ETIKET_W-1:0] etiket_c,
   output logic                hata_c
);

   localparam int unsigned N     = XLEN / ADIM_BIT;
   localparam int unsigned SAY_W = $clog2(N);
   localparam int unsigned P_W   = 2 * XLEN;

   durum_t              durum_q, durum_d;
   logic [SAY_W-1:0]    sayac_q, sayac_d;
   logic [3:0]          op_q, op_d;
   logic [ETIKET_W-1:0] etiket_q, etiket_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [P_W-1:0]      p_q, p_d;
   logic                neg_q, neg_d;
   logic                sifir_q, sifir_d;
   logic [XLEN-1:0]     sonuc_q, sonuc_d;
   logic [ETIKET_W-1:0] cikis_etiket_q, cikis_etiket_d;
   logic                hata_q, hata_d;

   logic [P_W-1:0]      p_adim;
   logic [P_W-1:0]      carpim;
   logic                kabul_al;
   logic                a_isaretli, b_isaretli, a_neg, b_neg;
   logic [XLEN-1:0]     a_mut, b_mut;

   carpma_adimi #(
      .XLEN     (XLEN),
      .ADIM_BIT (ADIM_BIT)
   ) u_adim (
      .a_mutlak (a_q),
      .p        (p_q),
      .p_yeni   (p_adim)
   );

   assign kabul_c   = (durum_q == BOS) || ((durum_q == SONUC) && oku_g);
   assign gecerli_c = (durum_q == SONUC);
   assign sonuc_c   = sonuc_q;
   assign etiket_c  = cikis_etiket_q;
   assign hata_c    = hata_q;
   assign kabul_al  = hazir_g && kabul_c && !iptal_g;

   // Signed product restored from magnitude product on the final step.
   assign carpim = neg_q ? (-p_adim) : p_adim;

   // Operand sign handling at issue; illegal codes are treated as unsigned.
   always_comb begin
      a_isaretli = (islev_kodu_g == OP_MUL) || (islev_kodu_g == OP_MULH) ||
                   (islev_kodu_g == OP_MULHSU);
      b_isaretli = (islev_kodu_g == OP_MUL) || (islev_kodu_g == OP_MULH);
      a_neg      = a_isaretli && islec1_g[XLEN-1];
      b_neg      = b_isaretli && islec2_g[XLEN-1];
      a_mut      = a_neg ? (-islec1_g) : islec1_g;
      b_mut      = b_neg ? (-islec2_g) : islec2_g;
   end

   // Next-state and datapath update.
   always_comb begin
      durum_d        = durum_q;
      sayac_d        = sayac_q;
      op_d           = op_q;
      etiket_d       = etiket_q;
      a_d            = a_q;
      p_d            = p_q;
      neg_d          = neg_q;
      sifir_d        = sifir_q;
      sonuc_d        = sonuc_q;
      cikis_etiket_d = cikis_etiket_q;
      hata_d         = hata_q;

      case (durum_q)
         BOS: begin
            if (kabul_al) durum_d = HESAPLA;
         end
         HESAPLA: begin
            if (iptal_g) begin
               durum_d = BOS;
            end else if (!kod_gecerli(op_q)) begin
               sonuc_d        = '0;
               hata_d         = 1'b1;
               cikis_etiket_d = etiket_q;
               durum_d        = SONUC;
            end else if (sifir_q) begin
               sonuc_d        = '0;
               hata_d         = 1'b0;
               cikis_etiket_d = etiket_q;
               durum_d        = SONUC;
            end else begin
               p_d = p_adim;
               if (sayac_q == SAY_W'(N - 1)) begin
                  sonuc_d        = (op_q == OP_MUL) ? carpim[XLEN-1:0] : carpim[P_W-1:XLEN];
                  hata_d         = 1'b0;
                  cikis_etiket_d = etiket_q;
                  durum_d        = SONUC;
               end else begin
                  sayac_d = sayac_q + SAY_W'(1);
               end
            end
         end
         SONUC: begin
            if (iptal_g)    durum_d = BOS;
            else if (oku_g) durum_d = hazir_g ? HESAPLA : BOS;
         end
         default: durum_d = BOS;
      endcase

      // Issue latch; also covers the back-to-back accept out of SONUC.
      if (kabul_al) begin
         op_d     = islev_kodu_g;
         etiket_d = etiket_g;
         a_d      = a_mut;
         p_d      = {{XLEN{1'b0}}, b_mut};
         neg_d    = a_neg ^ b_neg;
         sifir_d  = (a_mut == '0) || (b_mut == '0);
         sayac_d  = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_g) begin
      if (!rst_g) begin
         durum_q        <= BOS;
         sayac_q        <= '0;
         op_q           <= '0;
         etiket_q       <= '0;
         a_q            <= '0;
         p_q            <= '0;
         neg_q          <= 1'b0;
         sifir_q        <= 1'b0;
         sonuc_q        <= '0;
         cikis_etiket_q <= '0;
         hata_q         <= 1'b0;
      end else begin
         durum_q        <= durum_d;
         sayac_q        <= sayac_d;
         op_q           <= op_d;
         etiket_q       <= etiket_d;
         a_q            <= a_d;
         p_q            <= p_d;
         neg_q          <= neg_d;
         sifir_q        <= sifir_d;
         sonuc_q        <= sonuc_d;
         cikis_etiket_q <= cikis_etiket_d;
         hata_q         <= hata_d;
      end
   end

endmodule

// File: tb/tb_parametrik_carpma_birimi.sv
// Bench for parametrik_carpma_birimi: directed table and corner sequences on
// a 32-bit/2-bit instance, random ops on 64-bit instances with 1/4/8-bit steps.
module tb_parametrik_carpma_birimi;

   localparam logic [3:0] K_MUL    = 4'h1;
   localparam logic [3:0] K_MULH   = 4'h2;
   localparam logic [3:0] K_MULHU  = 4'h4;
   localparam logic [3:0] K_MULHSU = 4'h8;

   int toplam = 0;
   int hatali = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstr;

   task automatic chk(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
      toplam++;
      if (gercek !== beklenen) begin
         hatali++;
         $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
      end
   endtask

   function automatic logic [63:0] sec_islec();
      logic [63:0] v;
      case ($urandom_range(0, 9))
         0:       v = 64'h0;
         1:       v = 64'h8000_0000_0000_0000;
         2:       v = '1;
         3:       v = 64'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // ---------------- directed instance: XLEN=32, ADIM_BIT=2 ----------------
   logic        rst0, hazir0, kabul0, iptal0, gecerli0, oku0, hata0;
   logic [3:0]  kod0, et0, etc0;
   logic [31:0] i1, i2, sonuc0;

   parametrik_carpma_birimi #(.XLEN(32), .ADIM_BIT(2), .ETIKET_W(4)) u_dut0 (
      .clk_g(clk), .rst_g(rst0), .islev_kodu_g(kod0), .islec1_g(i1), .islec2_g(i2),
      .etiket_g(et0), .hazir_g(hazir0), .kabul_c(kabul0), .iptal_g(iptal0),
      .gecerli_c(gecerli0), .oku_g(oku0), .sonuc_c(sonuc0), .etiket_c(etc0), .hata_c(hata0)
   );

   // Issue one op into the idle unit and count edges until gecerli.
   task automatic islem0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output int lat);
      @(negedge clk);
      kod0 = op; i1 = a; i2 = b; et0 = tag; hazir0 = 1'b1;
      @(posedge clk); #1;
      hazir0 = 1'b0;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (gecerli0) break;
      end
   endtask

   task automatic oku_darbe0();
      @(negedge clk); oku0 = 1'b1;
      @(posedge clk); #1; oku0 = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] sonuc;
      logic        hata;
      int          lat;
   } vek_t;

   vek_t tablo[10];

   // ---------------- random instances: XLEN=64, ADIM_BIT=1/4/8 ----------------
   for (genvar g = 0; g < 3; g++) begin : g_rast
      localparam int unsigned AB = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
      localparam int unsigned X  = 64;
      logic [3:0]   kod, et, ec;
      logic [X-1:0] s1, s2, sn;
      logic         hz, kb, ip, gc, ok, ht;
      logic         bitti;

      parametrik_carpma_birimi #(.XLEN(X), .ADIM_BIT(AB), .ETIKET_W(4)) u_dut (
         .clk_g(clk), .rst_g(rstr), .islev_kodu_g(kod), .islec1_g(s1), .islec2_g(s2),
         .etiket_g(et), .hazir_g(hz), .kabul_c(kb), .iptal_g(ip),
         .gecerli_c(gc), .oku_g(ok), .sonuc_c(sn), .etiket_c(ec), .hata_c(ht)
      );

      initial begin
         logic [3:0]     op, tag;
         logic [X-1:0]   a, b, bek;
         logic [2*X-1:0] ae, be, pr;
         logic           bh;
         int             bl, lat;
         kod = '0; s1 = '0; s2 = '0; et = '0; hz = 1'b0; ip = 1'b0; ok = 1'b0;
         bitti = 1'b0;
         @(posedge rstr);
         repeat (2) @(posedge clk);
         for (int i = 0; i < 440; i++) begin
            op = 4'(1 << (i % 4));
            if (i % 11 == 10) begin
               op = 4'($urandom);
               if ($countones(op) == 1) op = 4'hC;
            end
            a   = sec_islec();
            b   = sec_islec();
            tag = 4'($urandom);
            // Reference: full-width product of sign- or zero-extended operands.
            ae = (op == K_MULHU) ? {{X{1'b0}}, a} : {{X{a[X-1]}}, a};
            be = (op == K_MUL || op == K_MULH) ? {{X{b[X-1]}}, b} : {{X{1'b0}}, b};
            pr = ae * be;
            if ($countones(op) != 1) begin
               bek = '0; bh = 1'b1; bl = 1;
            end else begin
               bek = (op == K_MUL) ? pr[X-1:0] : pr[2*X-1:X];
               bh  = 1'b0;
               bl  = (a == '0 || b == '0) ? 1 : int'(X / AB);
            end
            @(negedge clk);
            kod = op; s1 = a; s2 = b; et = tag; hz = 1'b1;
            @(posedge clk); #1;
            hz = 1'b0;
            lat = 0;
            while (lat < 200) begin
               @(posedge clk); #1;
               lat++;
               if (gc) break;
            end
            chk($sformatf("rnd_ab%0d_sonuc op=%0h a=%0h b=%0h", AB, op, a, b), 128'(sn), 128'(bek));
            chk($sformatf("rnd_ab%0d_hata op=%0h", AB, op), 128'(ht), 128'(bh));
            chk($sformatf("rnd_ab%0d_etiket", AB), 128'(ec), 128'(tag));
            chk($sformatf("rnd_ab%0d_gecikme op=%0h", AB, op), 128'(lat), 128'(bl));
            @(negedge clk); ok = 1'b1;
            @(posedge clk); #1; ok = 1'b0;
         end
         bitti = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat, gorulen;
      rstr = 1'b0; rst0 = 1'b0;
      kod0 = '0; i1 = '0; i2 = '0; et0 = '0; hazir0 = 1'b0; iptal0 = 1'b0; oku0 = 1'b0;

      tablo[0] = '{K_MUL,    32'd7,          32'hFFFF_FFFD, 4'h5, 32'hFFFF_FFEB, 1'b0, 16};
      tablo[1] = '{K_MULH,   32'h8000_0000,  32'h8000_0000, 4'h6, 32'h4000_0000, 1'b0, 16};
      tablo[2] = '{K_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'h7, 32'hFFFF_FFFE, 1'b0, 16};
      tablo[3] = '{K_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'h8, 32'hFFFF_FFFF, 1'b0, 16};
      tablo[4] = '{K_MULHU,  32'h0,          32'h1234,      4'h9, 32'h0,         1'b0, 1};
      tablo[5] = '{4'h3,     32'h55,         32'h66,        4'hA, 32'h0,         1'b1, 1};
      tablo[6] = '{K_MUL,    32'h1234_5678,  32'h10,        4'hB, 32'h2345_6780, 1'b0, 16};
      tablo[7] = '{K_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'hC, 32'h0,         1'b0, 16};
      tablo[8] = '{K_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 4'hD, 32'h8000_0000, 1'b0, 16};
      tablo[9] = '{4'h0,     32'h1,          32'h1,         4'hE, 32'h0,         1'b1, 1};

      repeat (3) @(posedge clk);
      #1;
      rstr = 1'b1; rst0 = 1'b1;

      chk("reset_gecerli", 128'(gecerli0), 128'(0));
      chk("reset_kabul",   128'(kabul0),   128'(1));
      chk("reset_sonuc",   128'(sonuc0),   128'(0));
      chk("reset_etiket",  128'(etc0),     128'(0));
      chk("reset_hata",    128'(hata0),    128'(0));

      for (int i = 0; i < 10; i++) begin
         islem0(tablo[i].op, tablo[i].a, tablo[i].b, tablo[i].tag, lat);
         chk($sformatf("tablo%0d_sonuc", i),   128'(sonuc0), 128'(tablo[i].sonuc));
         chk($sformatf("tablo%0d_hata", i),    128'(hata0),  128'(tablo[i].hata));
         chk($sformatf("tablo%0d_etiket", i),  128'(etc0),   128'(tablo[i].tag));
         chk($sformatf("tablo%0d_gecikme", i), 128'(lat),    128'(tablo[i].lat));
         oku_darbe0();
      end

      // Backpressure: hold the result, then consume and issue in the same edge.
      islem0(K_MUL, 32'd3, 32'd5, 4'h2, lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_gecerli", 128'(gecerli0), 128'(1));
         chk("bp_kabul",   128'(kabul0),   128'(0));
         chk("bp_sonuc",   128'(sonuc0),   128'(15));
         chk("bp_etiket",  128'(etc0),     128'(2));
      end
      @(negedge clk);
      kod0 = K_MULHU; i1 = 32'hFFFF_FFFF; i2 = 32'd2; et0 = 4'h9;
      hazir0 = 1'b1; oku0 = 1'b1;
      #1;
      chk("b2b_kabul_comb", 128'(kabul0), 128'(1));
      @(posedge clk); #1;
      hazir0 = 1'b0; oku0 = 1'b0;
      chk("b2b_gecerli_dustu", 128'(gecerli0), 128'(0));
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (gecerli0) break;
      end
      chk("b2b_gecikme", 128'(lat),    128'(16));
      chk("b2b_sonuc",   128'(sonuc0), 128'(1));
      chk("b2b_etiket",  128'(etc0),   128'(9));
      oku_darbe0();

      // Cancel at compute step 7.
      @(negedge clk);
      kod0 = K_MUL; i1 = 32'd11; i2 = 32'd13; et0 = 4'h4; hazir0 = 1'b1;
      @(posedge clk); #1;
      hazir0 = 1'b0;
      repeat (7) @(posedge clk);
      #1; iptal0 = 1'b1;
      @(posedge clk); #1;
      iptal0 = 1'b0;
      chk("iptal_gecerli", 128'(gecerli0), 128'(0));
      chk("iptal_kabul",   128'(kabul0),   128'(1));
      gorulen = 0;
      repeat (20) begin
         @(negedge clk);
         if (gecerli0) gorulen = 1;
      end
      chk("iptal_darbe_yok", 128'(gorulen), 128'(0));
      chk("iptal_sonuc_tutuldu", 128'(sonuc0), 128'(1));

      // Reset in the middle of an operation.
      @(negedge clk);
      kod0 = K_MUL; i1 = 32'd9; i2 = 32'd9; et0 = 4'hF; hazir0 = 1'b1;
      @(posedge clk); #1;
      hazir0 = 1'b0;
      repeat (5) @(posedge clk);
      #1; rst0 = 1'b0;
      @(posedge clk); #1;
      rst0 = 1'b1;
      chk("rst_orta_sonuc",   128'(sonuc0),   128'(0));
      chk("rst_orta_etiket",  128'(etc0),     128'(0));
      chk("rst_orta_hata",    128'(hata0),    128'(0));
      chk("rst_orta_gecerli", 128'(gecerli0), 128'(0));
      chk("rst_orta_kabul",   128'(kabul0),   128'(1));

      islem0(K_MUL, 32'd9, 32'd9, 4'h3, lat);
      chk("rst_sonrasi_sonuc",   128'(sonuc0), 128'(81));
      chk("rst_sonrasi_gecikme", 128'(lat),    128'(16));
      oku_darbe0();

      begin
         int c;
         c = 0;
         while (c < 60000 && !(g_rast[0].bitti && g_rast[1].bitti && g_rast[2].bitti)) begin
            @(posedge clk);
            c++;
         end
         chk("rastgele_tamamlandi", 128'(g_rast[0].bitti && g_rast[1].bitti && g_rast[2].bitti), 128'(1));
      end

      $display("test done: total=%0d bad=%0d", toplam, hatali);
      $finish;
   end

endmodule
